// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder (cla_pipe_adder).
package cla_pkg;

    localparam int unsigned GRP = 4;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Identity element for pg_cat when used as the high operand; pads unused tree leaves.
    localparam pg_t PG_ID = '{g: 1'b0, p: 1'b1};

    // Ceiling of log4(n): number of super-group levels above the 4-bit groups.
    function automatic int unsigned clog4(input int unsigned n);
        int unsigned d;
        int unsigned cap;
        d   = 0;
        cap = 1;
        while (cap < n) begin
            cap = cap * 4;
            d   = d + 1;
        end
        return d;
    endfunction

    function automatic pg_t pg_cat(input pg_t hi, input pg_t lo);
        pg_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: bitwise and group P/G from the operands, plus internal carries
// resolved from a supplied group carry in (the carry half may run a pipeline stage later).
module cla_group4
    import cla_pkg::*;
(
    input  logic [GRP-1:0] a_i,
    input  logic [GRP-1:0] b_i,
    output logic [GRP-1:0] p_o,
    output logic [GRP-1:0] g_o,
    output pg_t            pg_o,
    input  logic [GRP-1:0] cp_i,
    input  logic [GRP-1:0] cg_i,
    input  logic           cin_i,
    output logic [GRP-1:0] c_o
);

    assign p_o = a_i ^ b_i;
    assign g_o = a_i & b_i;

    assign pg_o.g = g_o[3]
                  | (p_o[3] & g_o[2])
                  | (p_o[3] & p_o[2] & g_o[1])
                  | (p_o[3] & p_o[2] & p_o[1] & g_o[0]);
    assign pg_o.p = &p_o;

    assign c_o[0] = cin_i;
    assign c_o[1] = cg_i[0] | (cp_i[0] & cin_i);
    assign c_o[2] = cg_i[1] | (cp_i[1] & cg_i[0]) | (cp_i[1] & cp_i[0] & cin_i);
    assign c_o[3] = cg_i[2]
                  | (cp_i[2] & cg_i[1])
                  | (cp_i[2] & cp_i[1] & cg_i[0])
                  | (cp_i[2] & cp_i[1] & cp_i[0] & cin_i);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Optional saturation on signed overflow when CLA_SAT_EN is defined.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PIPE_MID = 0
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_gout,
    output logic             out_pout
);

    localparam int unsigned NG = WIDTH / GRP;
    localparam int unsigned D  = clog4(NG);
    localparam int unsigned NL = 1 << (2 * D);

    logic             s1_v_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic             c0_q;

    logic             out_v_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             gout_q;
    logic             pout_q;

    logic             out_adv;
    logic             pm_ld;
    logic             s1_ld;

    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    pg_t  [NG-1:0]    s1_grp;

    logic             pm_v;
    logic [WIDTH-1:0] pm_p;
    logic [WIDTH-1:0] pm_g;
    pg_t  [NG-1:0]    pm_grp;
    logic             pm_c0;

    logic [NG-1:0]    grp_cin;
    logic [WIDTH-1:0] c_int;
    pg_t              root;
    logic             res_cout;
    logic             res_ovf;
    logic [WIDTH-1:0] res_sum;

    assign out_adv  = !out_v_q || out_ready;
    assign s1_ld    = !s1_v_q || pm_ld;
    assign in_ready = rst_n && s1_ld;

    // Input stage stores B' and c0 so subtraction costs nothing downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            a_q    <= '0;
            bx_q   <= '0;
            c0_q   <= 1'b0;
        end else if (s1_ld) begin
            s1_v_q <= in_valid;
            if (in_valid) begin
                a_q  <= in_a;
                bx_q <= in_sub ? ~in_b : in_b;
                c0_q <= in_sub | in_cin;
            end
        end
    end

    for (genvar k = 0; k < NG; k++) begin : g_grp
        cla_group4 u_grp (
            .a_i   (a_q[k*GRP +: GRP]),
            .b_i   (bx_q[k*GRP +: GRP]),
            .p_o   (s1_p[k*GRP +: GRP]),
            .g_o   (s1_g[k*GRP +: GRP]),
            .pg_o  (s1_grp[k]),
            .cp_i  (pm_p[k*GRP +: GRP]),
            .cg_i  (pm_g[k*GRP +: GRP]),
            .cin_i (grp_cin[k]),
            .c_o   (c_int[k*GRP +: GRP])
        );
    end

    if (PIPE_MID != 0) begin : g_mid
        logic             m_v_q;
        logic [WIDTH-1:0] m_p_q;
        logic [WIDTH-1:0] m_g_q;
        pg_t  [NG-1:0]    m_grp_q;
        logic             m_c0_q;

        assign pm_ld = !m_v_q || out_adv;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                m_v_q   <= 1'b0;
                m_p_q   <= '0;
                m_g_q   <= '0;
                m_grp_q <= '0;
                m_c0_q  <= 1'b0;
            end else if (pm_ld) begin
                m_v_q <= s1_v_q;
                if (s1_v_q) begin
                    m_p_q   <= s1_p;
                    m_g_q   <= s1_g;
                    m_grp_q <= s1_grp;
                    m_c0_q  <= c0_q;
                end
            end
        end

        assign pm_v   = m_v_q;
        assign pm_p   = m_p_q;
        assign pm_g   = m_g_q;
        assign pm_grp = m_grp_q;
        assign pm_c0  = m_c0_q;
    end else begin : g_nomid
        assign pm_ld  = out_adv;
        assign pm_v   = s1_v_q;
        assign pm_p   = s1_p;
        assign pm_g   = s1_g;
        assign pm_grp = s1_grp;
        assign pm_c0  = c0_q;
    end

    // Lookahead tree over 4-wide super-groups: P/G reduced upward, carries distributed downward.
    pg_t  up [0:D][0:NL-1];
    logic dn [0:D][0:NL-1];
    logic cw;

    always_comb begin
        cw      = 1'b0;
        grp_cin = '0;
        for (int unsigned l = 0; l <= D; l++) begin
            for (int unsigned i = 0; i < NL; i++) begin
                up[l][i] = PG_ID;
                dn[l][i] = 1'b0;
            end
        end
        for (int unsigned i = 0; i < NG; i++) begin
            up[0][i] = pm_grp[i];
        end
        for (int unsigned l = 0; l < D; l++) begin
            for (int unsigned j = 0; j < NL / GRP; j++) begin
                up[l+1][j] = pg_cat(pg_cat(up[l][GRP*j+3], up[l][GRP*j+2]),
                                    pg_cat(up[l][GRP*j+1], up[l][GRP*j]));
            end
        end
        dn[D][0] = pm_c0;
        for (int unsigned l = D; l > 0; l--) begin
            for (int unsigned j = 0; j < NL / GRP; j++) begin
                cw = dn[l][j];
                for (int unsigned k = 0; k < GRP; k++) begin
                    dn[l-1][GRP*j+k] = cw;
                    cw = up[l-1][GRP*j+k].g | (up[l-1][GRP*j+k].p & cw);
                end
            end
        end
        for (int unsigned i = 0; i < NG; i++) begin
            grp_cin[i] = dn[0][i];
        end
        root = up[D][0];
    end

    assign res_cout = root.g | (root.p & pm_c0);
    assign res_ovf  = res_cout ^ c_int[WIDTH-1];

`ifdef CLA_SAT_EN
    // Overflow implies equal operand signs, so g of the MSB gives the shared sign.
    always_comb begin
        res_sum = pm_p ^ c_int;
        if (res_ovf) begin
            res_sum = pm_g[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_sum = pm_p ^ c_int;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_v_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            gout_q  <= 1'b0;
            pout_q  <= 1'b0;
        end else if (out_adv) begin
            out_v_q <= pm_v;
            if (pm_v) begin
                sum_q  <= res_sum;
                cout_q <= res_cout;
                ovf_q  <= res_ovf;
                gout_q <= root.g;
                pout_q <= root.p;
            end
        end
    end

    assign out_valid = out_v_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_gout  = gout_q;
    assign out_pout  = pout_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: four configurations (16/0, 16/1, 4/0, 64/1)
// consume one shared operand stream in lockstep and are checked against a wide-arithmetic model.
`timescale 1ns/1ps
module tb_cla_pipe_adder;

    localparam int NCFG = 4;
    localparam int CW [NCFG] = '{16, 16, 4, 64};
    localparam int CP [NCFG] = '{0, 1, 0, 1};

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        go;
        logic        po;
        logic [31:0] t;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            out_ready;
    logic            tv;
    logic            tcin;
    logic            tsub;
    logic [63:0]     ta;
    logic [63:0]     tbv;
    logic            chk_lat;
    logic            done;
    logic [NCFG-1:0] rdy;
    logic [NCFG-1:0] ovld;
    logic            all_rdy;
    int unsigned     n_cmp   = 0;
    int unsigned     n_fail  = 0;
    logic [31:0]     cyc     = '0;
    int unsigned     pending [NCFG];

    assign all_rdy = &rdy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain (w+1)-bit arithmetic on A' and B' with sign-rule overflow.
    function automatic exp_t model(input int unsigned w, input logic [63:0] a64,
                                   input logic [63:0] b64, input logic cin, input logic sub);
        exp_t        r;
        logic [64:0] mask, a, bx, full, gen;
        logic        c0;
        mask = (65'd1 << w) - 65'd1;
        a    = {1'b0, a64} & mask;
        bx   = (sub ? {1'b0, ~b64} : {1'b0, b64}) & mask;
        c0   = sub ? 1'b1 : cin;
        full = a + bx + 65'(c0);
        gen  = a + bx;
        r.s  = full[63:0] & mask[63:0];
        r.co = full[w];
        r.ov = (a[w-1] == bx[w-1]) && (full[w-1] != a[w-1]);
        r.go = gen[w];
        r.po = ((a ^ bx) == mask);
        r.t  = cyc;
`ifdef CLA_SAT_EN
        if (r.ov) r.s = a[w-1] ? (64'd1 << (w - 1)) : (mask[63:0] >> 1);
`endif
        return r;
    endfunction

    for (genvar k = 0; k < NCFG; k++) begin : g_cfg
        localparam int W  = CW[k];
        localparam int PM = CP[k];

        logic         iv, rd, vo, co, ov, go, po;
        logic [W-1:0] so;
        exp_t         q [$];
        exp_t         e;
        logic         hv, hc, ho, hg, hp;
        logic [W-1:0] hs;

        assign iv      = tv & all_rdy;
        assign rdy[k]  = rd;
        assign ovld[k] = vo;

        cla_pipe_adder #(.WIDTH(W), .PIPE_MID(PM)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv),
            .in_ready  (rd),
            .in_a      (ta[W-1:0]),
            .in_b      (tbv[W-1:0]),
            .in_cin    (tcin),
            .in_sub    (tsub),
            .out_valid (vo),
            .out_ready (out_ready),
            .out_sum   (so),
            .out_cout  (co),
            .out_ovf   (ov),
            .out_gout  (go),
            .out_pout  (po)
        );

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                hv = 1'b0;
                check($sformatf("c%0d rst in_ready", k), 64'(rd), 64'(0));
                check($sformatf("c%0d rst out_valid", k), 64'(vo), 64'(0));
                check($sformatf("c%0d rst out_sum", k), 64'(so), 64'(0));
                check($sformatf("c%0d rst flags", k), 64'({co, ov, go, po}), 64'(0));
            end else begin
                if (hv) begin
                    check($sformatf("c%0d hold valid", k), 64'(vo), 64'(1));
                    check($sformatf("c%0d hold sum", k), 64'(so), 64'(hs));
                    check($sformatf("c%0d hold flags", k), 64'({co, ov, go, po}),
                          64'({hc, ho, hg, hp}));
                end
                if (vo && out_ready) begin
                    if (q.size() == 0) begin
                        check($sformatf("c%0d stale beat", k), 64'(vo), 64'(0));
                    end else begin
                        e = q.pop_front();
                        check($sformatf("c%0d sum", k), 64'(so), e.s);
                        check($sformatf("c%0d cout", k), 64'(co), 64'(e.co));
                        check($sformatf("c%0d ovf", k), 64'(ov), 64'(e.ov));
                        check($sformatf("c%0d gout", k), 64'(go), 64'(e.go));
                        check($sformatf("c%0d pout", k), 64'(po), 64'(e.po));
                        // Accept is sampled one half-cycle before its edge, hence the +1.
                        if (chk_lat)
                            check($sformatf("c%0d latency", k), 64'(cyc - e.t), 64'(PM + 2));
                    end
                end
                hv = vo && !out_ready;
                hs = so;
                hc = co;
                ho = ov;
                hg = go;
                hp = po;
                if (tv && all_rdy) q.push_back(model(W, ta, tbv, tcin, tsub));
                if (chk_lat) check($sformatf("c%0d free-flow in_ready", k), 64'(rd), 64'(1));
            end
            pending[k] = q.size();
        end
    end

    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb);
        logic        acc;
        int unsigned guard;
        tv    = 1'b1;
        ta    = a;
        tbv   = b;
        tcin  = ci;
        tsub  = sb;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 64) begin
            @(negedge clk);
            acc = all_rdy && rst_n;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("accept timeout", 64'(acc), 64'(1));
        tv = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        tv = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rand();
        send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < NCFG; i++) check(tag, 64'(pending[i]), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        tv        = 1'b0;
        ta        = '0;
        tbv       = '0;
        tcin      = 1'b0;
        tsub      = 1'b0;
        chk_lat   = 1'b0;
        done      = 1'b0;

        #2;
        check("reset in_ready", 64'(rdy), 64'(0));
        check("reset out_valid", 64'(ovld), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        chk_lat = 1'b1;
        send(64'hFFFF, 64'h0001, 1'b0, 1'b0); idle(4);
        send(64'h7FFF, 64'h0001, 1'b0, 1'b0); idle(4);
        send(64'h0005, 64'h0007, 1'b1, 1'b1); idle(4);
        send(64'h8000, 64'h0001, 1'b0, 1'b1); idle(4);
        send(64'h00FF, 64'hFF00, 1'b1, 1'b0); idle(4);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0); idle(4);
        send(64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 1'b0, 1'b1); idle(4);

        for (int i = 0; i < 100; i++) send_rand();
        idle(6);
        chk_lat = 1'b0;
        check_drained("drain after stream");

        fork
            begin
                for (int i = 0; i < 40; i++) send_rand();
            end
            begin
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(negedge clk);
                check("stall in_ready", 64'(rdy), 64'(0));
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(6);
        check_drained("drain after stall");

        out_ready = 1'b0;
        send_rand();
        send_rand();
        #2 rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(ovld), 64'(0));
        check("async reset in_ready", 64'(rdy), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post-reset out_valid", 64'(ovld), 64'(0));
        end

        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send_rand();
                    if ($urandom_range(0, 7) == 0) idle(1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(8);
        check_drained("drain after random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
